itrx_amba4_axilite_wr_arb: RTL and testbench
============================================

// Module: itrx_amba4_axilite_wr_arb
// PURPOSE
//  Round-robin arbiter sharing one AXI4-Lite slave write path (AW/W/B) among NM masters.
//  Sits between NM register-bus masters and a single AXI4-Lite write target.
//  One write outstanding at a time. Responses use OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
//  The read path is arbitrated by a separate block.
// PARAMETERS
//  NM      2   number of masters (2..8)
//  ADDR_W  32  address width
//  DATA_W  32  data width (32 or 64); strobe width SW = DATA_W/8
// PORTS
//  clk        in   1          clock, all logic rising-edge
//  rst_n      in   1          asynchronous reset, active-low
//  m_awvalid  in   NM         per-master AW valid
//  m_awready  out  NM         per-master AW ready
//  m_awaddr   in   NM*ADDR_W  per-master AW address, master i at [i*ADDR_W +: ADDR_W]
//  m_awprot   in   NM*3       per-master AW prot {instr,nonsec,priv}
//  m_wvalid   in   NM         per-master W valid
//  m_wready   out  NM         per-master W ready
//  m_wdata    in   NM*DATA_W  per-master write data
//  m_wstrb    in   NM*SW      per-master write strobes
//  m_bvalid   out  NM         per-master B valid
//  m_bready   in   NM         per-master B ready
//  m_bresp    out  NM*2       per-master B response
//  s_awvalid/s_awready  out/in  1/1  slave AW handshake
//  s_awaddr/s_awprot    out  ADDR_W/3  slave AW payload
//  s_wvalid/s_wready    out/in  1/1  slave W handshake
//  s_wdata/s_wstrb      out  DATA_W/SW  slave W payload
//  s_bvalid/s_bready    in/out  1/1  slave B handshake
//  s_bresp    in   2          slave B response
// BEHAVIOUR
//  Reset values
//   - FSM=IDLE, gnt=0, rr_ptr=0, aw_done=0, w_done=0.
//   - All ready/valid outputs 0; payload outputs 0.
//  IDLE
//   - Requesters are masters with m_awvalid=1 (m_wvalid is not required).
//   - Grant goes to the first requester found scanning rr_ptr, rr_ptr+1, ... mod NM.
//   - On a grant: gnt<=i, rr_ptr<=(i+1)%NM, clear aw_done/w_done, go to ADDR.
//   - No requester: stay in IDLE. One-cycle arbitration bubble.
//  ADDR
//   - AW forwarding: s_awvalid = m_awvalid[gnt] & ~aw_done.
//     m_awready[gnt] = s_awready & ~aw_done.
//   - W forwarding: s_wvalid = m_wvalid[gnt] & ~w_done.
//     m_wready[gnt] = s_wready & ~w_done.
//   - Payloads are muxed from gnt. Non-granted masters see ready=0.
//   - A handshake sets the matching done flag. AW and W may complete in either order or
//     the same cycle. When both are done (including same-cycle), go to RESP.
//  RESP
//   - s_bready = m_bready[gnt]; m_bvalid[gnt] = s_bvalid; m_bresp[gnt] = s_bresp.
//   - On the B handshake go to IDLE. A new grant follows on the next cycle.
//  Common rules
//   - m_bvalid/m_bresp are 0 for non-granted masters and in IDLE/ADDR.
//   - s_* valid never depends combinationally on s_* ready.
//   - Fairness: a requesting master waits at most NM-1 transactions.
//   - Reset mid-transaction: immediate return to IDLE with reset values; the in-flight
//     write is abandoned.
//   - A master dropping m_awvalid before its handshake is a protocol violation; an
//     SVA assertion flags it.
// TESTING
//  - Single write, NM=2: m0 aw=0x10, wdata=0xA5A5A5A5, strb=0xF; slave OKAY ->
//    s_awaddr=0x10 one cycle after request; m_bresp[0]=00; m_bvalid[1] never 1.
//  - Contention: m0 and m1 request continuously for 4 writes -> grant order 0,1,0,1;
//    rr_ptr ends at 0.
//  - W before AW: m1 wvalid 3 cycles before awvalid -> m_wready[1] stays 0 until the
//    grant; the write completes; s_wdata matches m1's data.
//  - Same-cycle AW+W handshake -> RESP entered next cycle; slave bvalid with SLVERR
//    (2'b10) -> m_bresp=10; B stalled 5 cycles by m_bready=0 -> s_bready held 0.
//  - Reset asserted in RESP with s_bvalid=1 -> all outputs 0 asynchronously; after
//    release, m1 request granted first (rr_ptr=0 and m0 idle).
//  - NM=4, DECERR (2'b11) from slave on m3 write -> routed only to m3; m0..m2 bvalid 0.

Source files
------------

// File: rtl/itrx_amba4_axilite_wr_arb.sv
// itrx_amba4_axilite_wr_arb
//   Round-robin arbiter that shares one AXI4-Lite write path (AW/W/B) among NM masters.
//   Only one write is in flight at a time. The FSM has three states:
//     IDLE picks a requester, ADDR forwards AW and W, and RESP routes B back.
//   Slave-side valids come only from master valids and registered done flags,
//   never from slave readies.

// Protocol checker: a master must keep AW valid raised until it is accepted.
module itrx_amba4_axilite_wr_arb_chk #(
    parameter int NM = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [NM-1:0] m_awvalid,
    input  logic [NM-1:0] m_awready
);
    for (genvar i = 0; i < NM; i++) begin : g_aw_hold
        a_aw_hold : assert property (@(posedge clk) disable iff (!rst_n)
            (m_awvalid[i] && !m_awready[i]) |=> m_awvalid[i]);
    end
endmodule

module itrx_amba4_axilite_wr_arb #(
    parameter int NM     = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NM-1:0]            m_awvalid,
    output logic [NM-1:0]            m_awready,
    input  logic [NM*ADDR_W-1:0]     m_awaddr,
    input  logic [NM*3-1:0]          m_awprot,
    input  logic [NM-1:0]            m_wvalid,
    output logic [NM-1:0]            m_wready,
    input  logic [NM*DATA_W-1:0]     m_wdata,
    input  logic [NM*(DATA_W/8)-1:0] m_wstrb,
    output logic [NM-1:0]            m_bvalid,
    input  logic [NM-1:0]            m_bready,
    output logic [NM*2-1:0]          m_bresp,
    output logic                     s_awvalid,
    input  logic                     s_awready,
    output logic [ADDR_W-1:0]        s_awaddr,
    output logic [2:0]               s_awprot,
    output logic                     s_wvalid,
    input  logic                     s_wready,
    output logic [DATA_W-1:0]        s_wdata,
    output logic [DATA_W/8-1:0]      s_wstrb,
    input  logic                     s_bvalid,
    output logic                     s_bready,
    input  logic [1:0]               s_bresp
);
    localparam int SW = DATA_W / 8;
    localparam int GW = (NM > 1) ? $clog2(NM) : 1;
    localparam logic [GW:0] NM_W = (GW + 1)'(NM);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] gnt_q, gnt_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;

    logic          req_found_s;
    logic [GW-1:0] pick_s;
    logic [GW:0]   scan_sum_s;
    logic [GW-1:0] scan_idx_s;
    logic          aw_hs_s;
    logic          w_hs_s;

    // Scan requesters starting at rr_ptr and pick the first one with AW valid raised.
    always_comb begin
        req_found_s = 1'b0;
        pick_s      = {GW{1'b0}};
        scan_sum_s  = {(GW + 1){1'b0}};
        scan_idx_s  = {GW{1'b0}};
        for (int k = 0; k < NM; k++) begin
            scan_sum_s = {1'b0, rr_ptr_q} + (GW + 1)'(k);
            if (scan_sum_s >= NM_W) begin
                scan_sum_s = scan_sum_s - NM_W;
            end else begin
                scan_sum_s = scan_sum_s;
            end
            scan_idx_s = scan_sum_s[GW-1:0];
            if (!req_found_s && m_awvalid[scan_idx_s]) begin
                req_found_s = 1'b1;
                pick_s      = scan_idx_s;
            end else begin
                pick_s = pick_s;
            end
        end
    end

    // Compute the next state and forward the channels of the granted master.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_ptr_d  = rr_ptr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        aw_hs_s   = 1'b0;
        w_hs_s    = 1'b0;
        m_awready = {NM{1'b0}};
        m_wready  = {NM{1'b0}};
        m_bvalid  = {NM{1'b0}};
        m_bresp   = {(NM * 2){1'b0}};
        s_awvalid = 1'b0;
        s_awaddr  = {ADDR_W{1'b0}};
        s_awprot  = 3'b000;
        s_wvalid  = 1'b0;
        s_wdata   = {DATA_W{1'b0}};
        s_wstrb   = {SW{1'b0}};
        s_bready  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_found_s) begin
                    gnt_d     = pick_s;
                    rr_ptr_d  = (pick_s == GW'(NM - 1)) ? {GW{1'b0}} : pick_s + GW'(1);
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                // Payloads are only driven while the address/data phase is open.
                s_awvalid         = m_awvalid[gnt_q] & ~aw_done_q;
                s_awaddr          = m_awaddr[gnt_q * ADDR_W +: ADDR_W];
                s_awprot          = m_awprot[gnt_q * 3 +: 3];
                m_awready[gnt_q]  = s_awready & ~aw_done_q;
                s_wvalid          = m_wvalid[gnt_q] & ~w_done_q;
                s_wdata           = m_wdata[gnt_q * DATA_W +: DATA_W];
                s_wstrb           = m_wstrb[gnt_q * SW +: SW];
                m_wready[gnt_q]   = s_wready & ~w_done_q;
                aw_hs_s           = s_awvalid & s_awready;
                w_hs_s            = s_wvalid & s_wready;
                if (aw_hs_s) begin
                    aw_done_d = 1'b1;
                end else begin
                    aw_done_d = aw_done_q;
                end
                if (w_hs_s) begin
                    w_done_d = 1'b1;
                end else begin
                    w_done_d = w_done_q;
                end
                // AW and W may finish in either order or together.
                if ((aw_done_q | aw_hs_s) & (w_done_q | w_hs_s)) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_RESP: begin
                s_bready                 = m_bready[gnt_q];
                m_bvalid[gnt_q]          = s_bvalid;
                m_bresp[gnt_q * 2 +: 2]  = s_bresp;
                if (s_bvalid & m_bready[gnt_q]) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Hold the FSM state, the grant, the round-robin pointer and the done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= {GW{1'b0}};
            rr_ptr_q  <= {GW{1'b0}};
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_ptr_q  <= rr_ptr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    itrx_amba4_axilite_wr_arb_chk #(.NM(NM)) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready)
    );

endmodule

// File: tb/tb_itrx_amba4_axilite_wr_arb.sv
// Directed testbench for itrx_amba4_axilite_wr_arb (NM=2 instance plus an NM=4 instance).
module tb_itrx_amba4_axilite_wr_arb;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    // NM=2 instance
    logic [1:0]  m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [63:0] m_awaddr, m_wdata;
    logic [5:0]  m_awprot;
    logic [7:0]  m_wstrb;
    logic [3:0]  m_bresp;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [31:0] s_awaddr, s_wdata;
    logic [2:0]  s_awprot;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp;

    // NM=4 instance
    logic [3:0]   q_m_awvalid, q_m_awready, q_m_wvalid, q_m_wready, q_m_bvalid, q_m_bready;
    logic [127:0] q_m_awaddr, q_m_wdata;
    logic [11:0]  q_m_awprot;
    logic [15:0]  q_m_wstrb;
    logic [7:0]   q_m_bresp;
    logic         q_s_awvalid, q_s_awready, q_s_wvalid, q_s_wready, q_s_bvalid, q_s_bready;
    logic [31:0]  q_s_awaddr, q_s_wdata;
    logic [2:0]   q_s_awprot;
    logic [3:0]   q_s_wstrb;
    logic [1:0]   q_s_bresp;

    int b1_cnt = 0;

    always #5 clk = ~clk;

    // Count cycles in which master 1 sees a B valid.
    always @(negedge clk) begin
        if (m_bvalid[1] === 1'b1) b1_cnt <= b1_cnt + 1;
    end

    itrx_amba4_axilite_wr_arb #(.NM(2), .ADDR_W(32), .DATA_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp)
    );

    itrx_amba4_axilite_wr_arb #(.NM(4), .ADDR_W(32), .DATA_W(32)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .m_awvalid(q_m_awvalid), .m_awready(q_m_awready), .m_awaddr(q_m_awaddr), .m_awprot(q_m_awprot),
        .m_wvalid(q_m_wvalid), .m_wready(q_m_wready), .m_wdata(q_m_wdata), .m_wstrb(q_m_wstrb),
        .m_bvalid(q_m_bvalid), .m_bready(q_m_bready), .m_bresp(q_m_bresp),
        .s_awvalid(q_s_awvalid), .s_awready(q_s_awready), .s_awaddr(q_s_awaddr), .s_awprot(q_s_awprot),
        .s_wvalid(q_s_wvalid), .s_wready(q_s_wready), .s_wdata(q_s_wdata), .s_wstrb(q_s_wstrb),
        .s_bvalid(q_s_bvalid), .s_bready(q_s_bready), .s_bresp(q_s_bresp)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_awvalid = 2'b00; m_awaddr = 64'h0; m_awprot = 6'h0;
        m_wvalid = 2'b00; m_wdata = 64'h0; m_wstrb = 8'h0; m_bready = 2'b00;
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = 2'b00;
        q_m_awvalid = 4'h0; q_m_awaddr = 128'h0; q_m_awprot = 12'h0;
        q_m_wvalid = 4'h0; q_m_wdata = 128'h0; q_m_wstrb = 16'h0; q_m_bready = 4'h0;
        q_s_awready = 1'b0; q_s_wready = 1'b0; q_s_bvalid = 1'b0; q_s_bresp = 2'b00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        m_awaddr = 64'h1234_5678_9ABC_DEF0; m_wdata = 64'hFFFF_0000_FFFF_0000; m_wstrb = 8'hFF;
        s_bvalid = 1'b1; s_bresp = 2'b11; m_bready = 2'b11;
        @(negedge clk);
        @(negedge clk);
        checks++; if ({s_awvalid, s_wvalid, s_bready} !== 3'b000) begin errors++; $display("FAIL reset_s_valids: got %b want 000", {s_awvalid, s_wvalid, s_bready}); end
        checks++; if ({m_awready, m_wready, m_bvalid} !== 6'b0) begin errors++; $display("FAIL reset_m_handshake: got %b want 000000", {m_awready, m_wready, m_bvalid}); end
        checks++; if ({s_awaddr, s_wdata, s_wstrb, s_awprot} !== 71'h0) begin errors++; $display("FAIL reset_payload: got %h want 0", {s_awaddr, s_wdata, s_wstrb, s_awprot}); end
        checks++; if (m_bresp !== 4'b0000) begin errors++; $display("FAIL reset_bresp: got %b want 0000", m_bresp); end
        step();
        clear_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        int b1_start;
        b1_start = b1_cnt;
        step();
        m_awvalid = 2'b01; m_awaddr[31:0] = 32'h10; m_awprot[2:0] = 3'b010;
        m_wvalid = 2'b01; m_wdata[31:0] = 32'hA5A5_A5A5; m_wstrb[3:0] = 4'hF;
        s_awready = 1'b1; s_wready = 1'b1; m_bready = 2'b01;
        @(negedge clk);
        checks++; if ({s_awvalid, s_wvalid, m_awready, m_wready} !== 6'b0) begin errors++; $display("FAIL single_idle_bubble: got %b want 000000", {s_awvalid, s_wvalid, m_awready, m_wready}); end
        step();
        @(negedge clk);
        checks++; if (s_awaddr !== 32'h10) begin errors++; $display("FAIL single_awaddr: got %h want 00000010", s_awaddr); end
        checks++; if (s_awprot !== 3'b010) begin errors++; $display("FAIL single_awprot: got %b want 010", s_awprot); end
        checks++; if ({s_wdata, s_wstrb} !== {32'hA5A5_A5A5, 4'hF}) begin errors++; $display("FAIL single_wpayload: got %h want a5a5a5a5f", {s_wdata, s_wstrb}); end
        checks++; if ({s_awvalid, s_wvalid, m_awready, m_wready} !== 6'b11_01_01) begin errors++; $display("FAIL single_addr_hs: got %b want 110101", {s_awvalid, s_wvalid, m_awready, m_wready}); end
        step();
        m_awvalid = 2'b00; m_wvalid = 2'b00; s_bvalid = 1'b1; s_bresp = 2'b00;
        @(negedge clk);
        checks++; if ({s_bready, m_bvalid, m_bresp} !== 7'b1_01_0000) begin errors++; $display("FAIL single_resp: got %b want 1010000", {s_bready, m_bvalid, m_bresp}); end
        step();
        s_bvalid = 1'b0; m_bready = 2'b00;
        @(negedge clk);
        checks++; if ({s_bready, m_bvalid} !== 3'b000) begin errors++; $display("FAIL single_done: got %b want 000", {s_bready, m_bvalid}); end
        checks++; if (b1_cnt !== b1_start) begin errors++; $display("FAIL single_m1_bvalid: got %0d cycles want %0d", b1_cnt - b1_start, 0); end
    endtask

    task automatic test_aw_then_w();
        step();
        m_awvalid = 2'b01; m_awaddr[31:0] = 32'h20; m_wvalid = 2'b01;
        m_wdata[31:0] = 32'h1122_3344; m_wstrb[3:0] = 4'hC;
        s_awready = 1'b1; s_wready = 1'b0; m_bready = 2'b01;
        step();
        @(negedge clk);
        checks++; if ({m_awready, m_wready} !== 4'b01_00) begin errors++; $display("FAIL awfirst_ready: got %b want 0100", {m_awready, m_wready}); end
        step();
        m_awvalid = 2'b00; s_wready = 1'b1;
        @(negedge clk);
        checks++; if ({s_awvalid, s_wvalid, m_wready, s_bready} !== 5'b0_1_01_0) begin errors++; $display("FAIL awfirst_wait_w: got %b want 01010", {s_awvalid, s_wvalid, m_wready, s_bready}); end
        step();
        m_wvalid = 2'b00; s_bvalid = 1'b1; s_bresp = 2'b00;
        @(negedge clk);
        checks++; if ({s_bready, m_bvalid} !== 3'b1_01) begin errors++; $display("FAIL awfirst_resp: got %b want 101", {s_bready, m_bvalid}); end
        step();
        s_bvalid = 1'b0; m_bready = 2'b00;
    endtask

    task automatic test_same_cycle_slverr();
        step();
        m_awvalid = 2'b01; m_awaddr[31:0] = 32'h24; m_wvalid = 2'b01;
        m_wdata[31:0] = 32'h0BAD_F00D; m_wstrb[3:0] = 4'h1;
        s_awready = 1'b1; s_wready = 1'b1; m_bready = 2'b00;
        step();
        @(negedge clk);
        checks++; if ({m_awready, m_wready} !== 4'b01_01) begin errors++; $display("FAIL slverr_addr: got %b want 0101", {m_awready, m_wready}); end
        step();
        m_awvalid = 2'b00; m_wvalid = 2'b00; s_bvalid = 1'b1; s_bresp = 2'b10;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (s_bready !== 1'b0) begin errors++; $display("FAIL slverr_stall_bready c%0d: got %b want 0", c, s_bready); end
            checks++; if ({m_bvalid, m_bresp} !== 6'b01_0010) begin errors++; $display("FAIL slverr_stall_b c%0d: got %b want 010010", c, {m_bvalid, m_bresp}); end
            step();
        end
        m_bready = 2'b01;
        @(negedge clk);
        checks++; if (s_bready !== 1'b1) begin errors++; $display("FAIL slverr_release: got %b want 1", s_bready); end
        step();
        s_bvalid = 1'b0; s_bresp = 2'b00; m_bready = 2'b00;
        @(negedge clk);
        checks++; if (m_bvalid !== 2'b00) begin errors++; $display("FAIL slverr_done: got %b want 00", m_bvalid); end
    endtask

    task automatic test_w_before_aw();
        step();
        m_wvalid = 2'b10; m_wdata[63:32] = 32'hDEAD_BEEF; m_wstrb[7:4] = 4'h3;
        m_awaddr[63:32] = 32'h44; s_awready = 1'b1; s_wready = 1'b1; m_bready = 2'b10;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if ({m_wready, s_wvalid} !== 3'b000) begin errors++; $display("FAIL wfirst_hold c%0d: got %b want 000", c, {m_wready, s_wvalid}); end
            step();
        end
        m_awvalid = 2'b10;
        @(negedge clk);
        checks++; if (m_wready !== 2'b00) begin errors++; $display("FAIL wfirst_before_grant: got %b want 00", m_wready); end
        step();
        @(negedge clk);
        checks++; if ({m_awready, m_wready} !== 4'b10_10) begin errors++; $display("FAIL wfirst_grant: got %b want 1010", {m_awready, m_wready}); end
        checks++; if ({s_awaddr, s_wdata, s_wstrb} !== {32'h44, 32'hDEAD_BEEF, 4'h3}) begin errors++; $display("FAIL wfirst_payload: got %h want 00000044deadbeef3", {s_awaddr, s_wdata, s_wstrb}); end
        step();
        m_awvalid = 2'b00; m_wvalid = 2'b00; s_bvalid = 1'b1; s_bresp = 2'b00;
        @(negedge clk);
        checks++; if (m_bvalid !== 2'b10) begin errors++; $display("FAIL wfirst_resp: got %b want 10", m_bvalid); end
        step();
        s_bvalid = 1'b0; m_bready = 2'b00;
    endtask

    task automatic test_contention();
        int exp_order[4] = '{0, 1, 0, 1};
        int n = 0;
        int c0 = 0;
        int c1 = 0;
        int g;
        step();
        m_awaddr = {32'h200, 32'h100}; m_wdata = {32'h2222_2222, 32'h1111_1111}; m_wstrb = 8'hFF;
        m_awvalid = 2'b11; m_wvalid = 2'b11; m_bready = 2'b11;
        s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1; s_bresp = 2'b00;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            @(negedge clk);
            if (m_awready !== 2'b00) begin
                g = (m_awready === 2'b10) ? 1 : 0;
                checks++; if (g !== exp_order[n]) begin errors++; $display("FAIL contention_grant%0d: got m%0d (awready %b) want m%0d", n, g, m_awready, exp_order[n]); end
                checks++; if (s_awaddr !== ((exp_order[n] == 0) ? 32'h100 : 32'h200)) begin errors++; $display("FAIL contention_addr%0d: got %h", n, s_awaddr); end
                n++;
                if (g == 0) c0++; else c1++;
                step();
                if (g == 0 && c0 == 2) begin m_awvalid[0] = 1'b0; m_wvalid[0] = 1'b0; end
                if (g == 1 && c1 == 2) begin m_awvalid[1] = 1'b0; m_wvalid[1] = 1'b0; end
            end
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL contention_timeout: got %0d grants want 4", n); end
        m_awvalid = 2'b00; m_wvalid = 2'b00;
        step();
        s_bvalid = 1'b0; m_bready = 2'b00;
        @(negedge clk);
        checks++; if (u_dut.rr_ptr_q !== 1'b0) begin errors++; $display("FAIL contention_rr_ptr: got %b want 0", u_dut.rr_ptr_q); end
    endtask

    task automatic test_reset_in_resp();
        step();
        m_awvalid = 2'b01; m_awaddr = {32'h40, 32'h30}; m_wvalid = 2'b01;
        m_wdata = {32'h4444_4444, 32'h3333_3333}; m_wstrb = 8'hFF;
        s_awready = 1'b1; s_wready = 1'b1; m_bready = 2'b00;
        step();
        @(negedge clk);
        checks++; if (m_awready !== 2'b01) begin errors++; $display("FAIL rstresp_addr: got %b want 01", m_awready); end
        step();
        m_awvalid = 2'b00; m_wvalid = 2'b00; s_bvalid = 1'b1; s_bresp = 2'b11;
        @(negedge clk);
        checks++; if ({m_bvalid, m_bresp} !== 6'b01_0011) begin errors++; $display("FAIL rstresp_pre: got %b want 010011", {m_bvalid, m_bresp}); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({m_awready, m_wready, m_bvalid, s_bready, s_awvalid, s_wvalid} !== 9'b0) begin errors++; $display("FAIL rstresp_async: got %b want 000000000", {m_awready, m_wready, m_bvalid, s_bready, s_awvalid, s_wvalid}); end
        checks++; if (m_bresp !== 4'b0000) begin errors++; $display("FAIL rstresp_bresp: got %b want 0000", m_bresp); end
        step();
        s_bvalid = 1'b0; s_bresp = 2'b00;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (u_dut.rr_ptr_q !== 1'b0) begin errors++; $display("FAIL rstresp_rr_ptr: got %b want 0", u_dut.rr_ptr_q); end
        step();
        m_awvalid = 2'b10; m_wvalid = 2'b10; m_bready = 2'b10;
        step();
        @(negedge clk);
        checks++; if ({m_awready, s_awaddr} !== {2'b10, 32'h40}) begin errors++; $display("FAIL rstresp_m1_grant: got %h want 200000040", {m_awready, s_awaddr}); end
        step();
        m_awvalid = 2'b00; m_wvalid = 2'b00; s_bvalid = 1'b1;
        @(negedge clk);
        checks++; if (m_bvalid !== 2'b10) begin errors++; $display("FAIL rstresp_m1_resp: got %b want 10", m_bvalid); end
        step();
        s_bvalid = 1'b0; m_bready = 2'b00;
    endtask

    task automatic test_nm4_decerr();
        step();
        q_m_awvalid = 4'b1000; q_m_awaddr[127:96] = 32'h300; q_m_wvalid = 4'b1000;
        q_m_wdata[127:96] = 32'hCAFE_0003; q_m_wstrb[15:12] = 4'hF;
        q_s_awready = 1'b1; q_s_wready = 1'b1; q_m_bready = 4'b1111;
        step();
        @(negedge clk);
        checks++; if ({q_m_awready, q_s_awaddr} !== {4'b1000, 32'h300}) begin errors++; $display("FAIL nm4_grant: got %h want 800000300", {q_m_awready, q_s_awaddr}); end
        step();
        q_m_awvalid = 4'h0; q_m_wvalid = 4'h0; q_s_bvalid = 1'b1; q_s_bresp = 2'b11;
        @(negedge clk);
        checks++; if (q_m_bvalid !== 4'b1000) begin errors++; $display("FAIL nm4_bvalid: got %b want 1000", q_m_bvalid); end
        checks++; if (q_m_bresp !== 8'b11_00_00_00) begin errors++; $display("FAIL nm4_bresp: got %b want 11000000", q_m_bresp); end
        step();
        q_s_bvalid = 1'b0; q_s_bresp = 2'b00; q_m_bready = 4'h0;
        @(negedge clk);
        checks++; if (q_m_bvalid !== 4'b0000) begin errors++; $display("FAIL nm4_done: got %b want 0000", q_m_bvalid); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_aw_then_w();
        test_same_cycle_slverr();
        test_w_before_aw();
        test_contention();
        test_reset_in_resp();
        test_nm4_decerr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
